// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES permutation tables, S-boxes, key schedule and FSM encoding
package des_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int IP [1:64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP [1:64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25
    };

    localparam int E [1:48] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int P [1:32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    localparam int PC1 [1:56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [1:48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Entry i is the left-rotation applied in encrypt round i+1
    localparam logic [1:0] SHIFT [0:15] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Each S-box is row-major: index = {row(2), col(4)}
    localparam logic [3:0] SBOX [0:7][0:63] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
           0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
          15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
           3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
          13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
           1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
          13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
           3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
          14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
          11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
          10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
           4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
          13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
           6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
           1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
           2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
    };

    // Decrypt walks the schedule backwards: round 1 reuses C16 = C0 (no shift)
    function automatic logic [1:0] rot_amount(input logic [4:0] n, input logic dec);
        logic [4:0] idx;
        if (dec) begin
            if (n <= 5'd1) return 2'd0;
            idx = 5'd17 - n;
        end else begin
            idx = n - 5'd1;
        end
        return SHIFT[4'(idx)];
    endfunction

    function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] amt,
                                          input logic dec);
        logic [27:0] y;
        y = x;
        case ({dec, amt})
            3'b001:  y = {x[26:0], x[27]};
            3'b010:  y = {x[25:0], x[27:26]};
            3'b101:  y = {x[0], x[27:1]};
            3'b110:  y = {x[1:0], x[27:2]};
            default: y = x;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/des_iter_core_f.sv
// rtl/des_iter_core_f.sv - combinational DES round function f(R, K)
module des_f
    import des_pkg::*;
(
    input  logic [32:1] r,
    input  logic [48:1] k,
    output logic [32:1] f
);

    // Internally DES bit n of a W-bit word sits at index W-n
    logic [31:0] r0;
    logic [47:0] e;
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] p;

    assign r0 = r;

    for (genvar i = 1; i <= 48; i++) begin : g_e
        assign e[48-i] = r0[32-E[i]];
    end

    assign x = e ^ k;

    for (genvar j = 0; j < 8; j++) begin : g_sbox
        assign s[31-4*j -: 4] = SBOX[j][{x[47-6*j], x[42-6*j], x[46-6*j -: 4]}];
    end

    for (genvar i = 1; i <= 32; i++) begin : g_p
        assign p[32-i] = s[32-P[i]];
    end

    assign f = p;

endmodule

// File: rtl/des_iter_core.sv
// rtl/des_iter_core.sv - iterative one-round-per-clock DES encrypt/decrypt engine
module des_iter_core
    import des_pkg::*;
#(
    parameter int ROUNDS = 16,
    parameter int CNT_W  = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [64:1] in_block,
    input  logic [64:1] in_key,
    input  logic        in_decrypt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [64:1] out_block,
    output logic        busy
);

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        l_reg, r_reg;
    logic [27:0]        c_reg, d_reg;
    logic               mode;

    logic [63:0]        blk0, key0, ip_out, fp_in, fp_out;
    logic [55:0]        pc1_out, cd_rot;
    logic [47:0]        k;
    logic [31:0]        f_out, r_new;
    logic [27:0]        c_rot, d_rot;
    logic [1:0]         amt;
    logic               load, step, last;
    logic               unused_parity;

    assign blk0 = in_block;
    assign key0 = in_key;
    assign unused_parity = ^{key0[56], key0[48], key0[40], key0[32],
                             key0[24], key0[16], key0[8], key0[0]};

    for (genvar i = 1; i <= 64; i++) begin : g_ip
        assign ip_out[64-i] = blk0[64-IP[i]];
    end

    for (genvar i = 1; i <= 56; i++) begin : g_pc1
        assign pc1_out[56-i] = key0[64-PC1[i]];
    end

    // Subkey for round cnt comes from C/D rotated by this round's schedule step
    assign amt    = rot_amount(5'(cnt), mode);
    assign c_rot  = rot28(c_reg, amt, mode);
    assign d_rot  = rot28(d_reg, amt, mode);
    assign cd_rot = {c_rot, d_rot};

    for (genvar i = 1; i <= 48; i++) begin : g_pc2
        assign k[48-i] = cd_rot[56-PC2[i]];
    end

    des_f u_f (
        .r (r_reg),
        .k (k),
        .f (f_out)
    );

    assign r_new = l_reg ^ f_out;
    assign fp_in = {r_new, r_reg};

    for (genvar i = 1; i <= 64; i++) begin : g_fp
        assign fp_out[64-i] = fp_in[64-FP[i]];
    end

    assign last = (cnt == CNT_W'(ROUNDS));

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last) state_next = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            l_reg     <= '0;
            r_reg     <= '0;
            c_reg     <= '0;
            d_reg     <= '0;
            mode      <= 1'b0;
            out_block <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                l_reg <= ip_out[63:32];
                r_reg <= ip_out[31:0];
                c_reg <= pc1_out[55:28];
                d_reg <= pc1_out[27:0];
                mode  <= in_decrypt;
                cnt   <= CNT_W'(1);
            end else if (step) begin
                l_reg <= r_reg;
                r_reg <= r_new;
                c_reg <= c_rot;
                d_reg <= d_rot;
                cnt   <= cnt + CNT_W'(1);
                if (last) out_block <= fp_out;
            end
        end
    end

endmodule

// File: tb/tb_des_iter_core.sv
// tb/tb_des_iter_core.sv - directed-vector self-checking bench for des_iter_core
module tb_des_iter_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [64:1] in_block;
    logic [64:1] in_key;
    logic        in_decrypt;
    logic        out_valid;
    logic        out_ready;
    logic [64:1] out_block;
    logic        busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    des_iter_core dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_block   (in_block),
        .in_key     (in_key),
        .in_decrypt (in_decrypt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_block  (out_block),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [63:0] key, input logic [63:0] blk, input logic dec);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready before issue", in_ready, 1'b1);
        in_key     = key;
        in_block   = blk;
        in_decrypt = dec;
        in_valid   = 1'b1;
        tick();
        in_valid   = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic finish_op(input string tag, input logic [63:0] exp);
        int n;
        wait_done(n);
        check({tag, " latency"}, 64'(n), 64'd16);
        check({tag, " result"}, out_block, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " in_ready after drain"}, in_ready, 1'b1);
        check({tag, " out_valid after drain"}, out_valid, 1'b0);
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_block   = '0;
        in_key     = '0;
        in_decrypt = 1'b0;
        out_ready  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset in_ready", in_ready, 1'b1);
        check("reset out_valid", out_valid, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset out_block", out_block, 64'h0);

        start_op(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0);
        check("busy in run", busy, 1'b1);
        check("in_ready in run", in_ready, 1'b0);
        wait_done(n);
        check("enc1 latency", 64'(n), 64'd16);
        check("enc1 result", out_block, 64'h85E813540F0AB405);
        check("enc1 C/D back to PC1", {8'h0, dut.c_reg, dut.d_reg}, 64'h00F0CCAAF556678F);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        start_op(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1);
        finish_op("dec1", 64'h0123456789ABCDEF);

        start_op(64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0);
        finish_op("enc2", 64'h0000000000000000);

        start_op(64'h0F339333EB6C0C72, 64'h8787878787878787, 1'b0);
        finish_op("enc2 parity flipped", 64'h0000000000000000);

        start_op(64'h0000000000000000, 64'h0000000000000000, 1'b0);
        finish_op("enc zero", 64'h8CA64DE9C1B123A7);

        // Backpressure: result held while new input is waved at the core
        start_op(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0);
        wait_done(n);
        check("bp latency", 64'(n), 64'd16);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_key   = 64'h0;
            in_block = 64'h0;
            tick();
            check("bp out_block stable", out_block, 64'h85E813540F0AB405);
            check("bp in_ready low", in_ready, 1'b0);
            check("bp out_valid held", out_valid, 1'b1);
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp no same-cycle accept", busy, 1'b0);
        check("bp in_ready after drain", in_ready, 1'b1);
        start_op(64'h0000000000000000, 64'h0000000000000000, 1'b0);
        finish_op("bp second block", 64'h8CA64DE9C1B123A7);

        // Reset during round 8, with in_valid asserted alongside reset
        start_op(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0);
        repeat (7) tick();
        rst      = 1'b1;
        in_valid = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("midreset out_valid", out_valid, 1'b0);
        check("midreset in_ready", in_ready, 1'b1);
        check("midreset busy", busy, 1'b0);
        check("midreset out_block", out_block, 64'h0);
        repeat (20) tick();
        check("midreset no stale result", out_valid, 1'b0);
        start_op(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0);
        finish_op("post-reset enc1", 64'h85E813540F0AB405);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
